prefetch_queue: RTL and testbench

//  Code prefetcher directly upstream of bus_interface_unit. Issues sequential dword code

---
 rtl/prefetch_queue_if.sv | 31 +++
 rtl/prefetch_queue.sv | 76 +++++++
 tb/tb_prefetch_queue.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prefetch_queue_if.sv
// Code-port and queue-port signals of the prefetcher.
// master: prefetch_queue side; slave: BIU/decoder/flush source side.
interface prefetch_queue_if #(
   parameter int DEPTH = 4
) ();
   localparam int CW = $clog2(DEPTH + 1);

   logic          i_flush;
   logic [31:0]   i_flush_address;
   logic          o_code_vaild;
   logic          i_code_ready;
   logic [31:0]   o_code_address;
   logic [31:0]   i_code_data_read;
   logic          o_queue_vaild;
   logic          i_queue_ready;
   logic [31:0]   o_queue_data;
   logic [31:0]   o_queue_address;
   logic [CW-1:0] o_queue_count;

   modport master (
      input  i_flush, i_flush_address, i_code_ready, i_code_data_read, i_queue_ready,
      output o_code_vaild, o_code_address, o_queue_vaild, o_queue_data, o_queue_address,
             o_queue_count
   );

   modport slave (
      output i_flush, i_flush_address, i_code_ready, i_code_data_read, i_queue_ready,
      input  o_code_vaild, o_code_address, o_queue_vaild, o_queue_data, o_queue_address,
             o_queue_count
   );
endinterface

// File: rtl/prefetch_queue.sv
// Sequential dword code prefetcher with a DEPTH-entry FIFO of {data, address};
// a flush discards queued and in-flight code and restarts at a new address.
module prefetch_queue #(
   parameter int          DEPTH         = 4,
   parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
   input logic              i_clock,
   input logic              i_reset_n,
   prefetch_queue_if.master bus
);
   localparam int            PW   = $clog2(DEPTH);
   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state;
   logic [31:0]   code_address;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   addr_mem [DEPTH];
   logic          push;
   logic          pop;

   always_comb begin
      pop        = (count != '0) & bus.i_queue_ready;
      push       = (state == REQ) & bus.i_code_ready & ~bus.i_flush;
      count_next = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state        <= IDLE;
         code_address <= RESET_ADDRESS & 32'hFFFF_FFFC;
         count        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            data_mem[i] <= '0;
            addr_mem[i] <= '0;
         end
      end else if (bus.i_flush) begin
         count        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         code_address <= bus.i_flush_address & 32'hFFFF_FFFC;
         // An outstanding fetch not answered this cycle must be drained before reuse
         state        <= (state == IDLE || bus.i_code_ready) ? REQ : DROP;
      end else begin
         if (push) begin
            data_mem[wr_ptr] <= bus.i_code_data_read;
            addr_mem[wr_ptr] <= code_address;
            wr_ptr           <= wr_ptr + 1'b1;
            code_address     <= code_address + 32'd4;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         case (state)
            IDLE:    if (count < FULL) state <= REQ;
            REQ:     if (bus.i_code_ready) state <= (count_next < FULL) ? REQ : IDLE;
            DROP:    if (bus.i_code_ready) state <= REQ;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_code_vaild    = (state != IDLE) & ~bus.i_code_ready;
   assign bus.o_code_address  = code_address;
   assign bus.o_queue_vaild   = (count != '0);
   assign bus.o_queue_data    = data_mem[rd_ptr];
   assign bus.o_queue_address = addr_mem[rd_ptr];
   assign bus.o_queue_count   = count;
endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue with a latency-configurable BIU responder
// that returns address ^ KEY for each captured fetch request.
module tb_prefetch_queue;
   localparam logic [31:0] KEY = 32'h5A5A_C3C3;

   logic i_clock   = 1'b0;
   logic i_reset_n = 1'b0;
   always #5 i_clock = ~i_clock;

   prefetch_queue_if #(.DEPTH(4)) bus ();

   prefetch_queue #(.DEPTH(4), .RESET_ADDRESS(32'hFFFF_FFF0)) dut (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .bus       (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          lat   = 2;
   logic [31:0] fetch_log [$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // BIU: captures one request, answers `lat` cycles later with a one-cycle ready pulse
   initial begin
      bit          pend     = 1'b0;
      int          wcnt     = 0;
      logic [31:0] req_addr = '0;
      bus.i_code_ready     = 1'b0;
      bus.i_code_data_read = '0;
      forever begin
         @(posedge i_clock);
         #1 bus.i_code_ready = 1'b0;
         #1;
         if (!i_reset_n) begin
            pend = 1'b0;
         end else if (pend) begin
            if (wcnt <= 1) begin
               bus.i_code_ready     = 1'b1;
               bus.i_code_data_read = req_addr ^ KEY;
               pend                 = 1'b0;
               #1 check_val("code_vaild_masked", 32'(bus.o_code_vaild), 32'd0);
            end else begin
               wcnt--;
            end
         end else if (bus.o_code_vaild) begin
            pend     = 1'b1;
            wcnt     = lat;
            req_addr = bus.o_code_address;
            fetch_log.push_back(req_addr);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge i_clock);
   endtask

   task automatic do_reset();
      @(negedge i_clock);
      i_reset_n           = 1'b0;
      bus.i_flush         = 1'b0;
      bus.i_flush_address = '0;
      bus.i_queue_ready   = 1'b0;
      tick(2);
      fetch_log.delete();
      i_reset_n = 1'b1;
   endtask

   task automatic wait_log(input int n, input int budget);
      int k = 0;
      while (fetch_log.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check_val("wait_log_timeout", 32'(fetch_log.size() >= n), 32'd1);
   endtask

   task automatic wait_count(input int target, input int budget);
      int k = 0;
      while (32'(bus.o_queue_count) != target && k < budget) begin
         tick(1);
         k++;
      end
      check_val("wait_count_timeout", 32'(bus.o_queue_count), 32'(target));
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_code_vaild"}, 32'(bus.o_code_vaild), 32'd0);
      check_val({tag, "_code_addr"}, bus.o_code_address, 32'hFFFF_FFF0);
      check_val({tag, "_count"}, 32'(bus.o_queue_count), 32'd0);
      check_val({tag, "_q_vaild"}, 32'(bus.o_queue_vaild), 32'd0);
      check_val({tag, "_q_data"}, bus.o_queue_data, 32'd0);
      check_val({tag, "_q_addr"}, bus.o_queue_address, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_addr;
      logic [31:0] exp_next;
      logic [31:0] cnt;
      logic        vq;
      logic        rdy;

      bus.i_flush         = 1'b0;
      bus.i_flush_address = '0;
      bus.i_queue_ready   = 1'b0;
      @(negedge i_clock);
      check_reset_outputs("rst");

      // 1: continuous pop, 2-cycle BIU -> sequential fetches with address wrap
      do_reset();
      lat               = 2;
      bus.i_queue_ready = 1'b1;
      wait_log(5, 200);
      check_val("t1_f0", fetch_log[0], 32'hFFFF_FFF0);
      check_val("t1_f1", fetch_log[1], 32'hFFFF_FFF4);
      check_val("t1_f2", fetch_log[2], 32'hFFFF_FFF8);
      check_val("t1_f3", fetch_log[3], 32'hFFFF_FFFC);
      check_val("t1_f4", fetch_log[4], 32'h0000_0000);

      // 2: no pops -> queue fills to 4 and fetching stops; one pop refills one
      do_reset();
      lat = 2;
      wait_count(4, 100);
      tick(20);
      check_val("t2_nfetch", 32'(fetch_log.size()), 32'd4);
      check_val("t2_idle", 32'(bus.o_code_vaild), 32'd0);
      check_val("t2_count", 32'(bus.o_queue_count), 32'd4);
      check_val("t2_head_addr", bus.o_queue_address, 32'hFFFF_FFF0);
      check_val("t2_head_data", bus.o_queue_data, 32'hFFFF_FFF0 ^ KEY);
      bus.i_queue_ready = 1'b1;
      tick(1);
      bus.i_queue_ready = 1'b0;
      check_val("t2_pop_count", 32'(bus.o_queue_count), 32'd3);
      check_val("t2_pop_head", bus.o_queue_address, 32'hFFFF_FFF4);
      tick(20);
      check_val("t2_refetch_n", 32'(fetch_log.size()), 32'd5);
      check_val("t2_refetch_a", fetch_log[4], 32'h0000_0000);
      check_val("t2_refill", 32'(bus.o_queue_count), 32'd4);
      check_val("t2_idle2", 32'(bus.o_code_vaild), 32'd0);

      // 3: flush while a fetch is outstanding -> response dropped
      do_reset();
      lat = 4;
      tick(1);
      check_val("t3_req", 32'(bus.o_code_vaild), 32'd1);
      bus.i_flush         = 1'b1;
      bus.i_flush_address = 32'h0000_1003;
      tick(1);
      bus.i_flush = 1'b0;
      check_val("t3_addr", bus.o_code_address, 32'h0000_1000);
      check_val("t3_drop_vaild", 32'(bus.o_code_vaild), 32'd1);
      check_val("t3_empty", 32'(bus.o_queue_count), 32'd0);
      wait_count(4, 150);
      check_val("t3_log0", fetch_log[0], 32'hFFFF_FFF0);
      check_val("t3_log1", fetch_log[1], 32'h0000_1000);
      check_val("t3_nfetch", 32'(fetch_log.size()), 32'd5);
      check_val("t3_head_addr", bus.o_queue_address, 32'h0000_1000);
      check_val("t3_head_data", bus.o_queue_data, 32'h0000_1000 ^ KEY);

      // 4: flush on the same edge as a response and a pop
      do_reset();
      lat = 2;
      wait_count(2, 100);
      begin
         int k = 0;
         while (!bus.i_code_ready && k < 20) begin
            tick(1);
            k++;
         end
      end
      check_val("t4_ready_seen", 32'(bus.i_code_ready), 32'd1);
      bus.i_flush         = 1'b1;
      bus.i_flush_address = 32'h0000_2002;
      bus.i_queue_ready   = 1'b1;
      tick(1);
      bus.i_flush       = 1'b0;
      bus.i_queue_ready = 1'b0;
      check_val("t4_count", 32'(bus.o_queue_count), 32'd0);
      check_val("t4_q_vaild", 32'(bus.o_queue_vaild), 32'd0);
      check_val("t4_addr", bus.o_code_address, 32'h0000_2000);
      check_val("t4_req", 32'(bus.o_code_vaild), 32'd1);
      wait_count(1, 50);
      check_val("t4_log3", fetch_log[3], 32'h0000_2000);
      check_val("t4_head_addr", bus.o_queue_address, 32'h0000_2000);
      check_val("t4_head_data", bus.o_queue_data, 32'h0000_2000 ^ KEY);

      // 5: 1-cycle BIU, continuous pop after a 2-entry prefill
      do_reset();
      lat = 1;
      wait_count(2, 50);
      bus.i_queue_ready = 1'b1;
      exp_addr          = 32'hFFFF_FFF0;
      for (int c = 0; c < 40; c++) begin
         cnt = 32'(bus.o_queue_count);
         vq  = bus.o_queue_vaild;
         rdy = bus.i_code_ready;
         if (vq) begin
            check_val("t5_order_addr", bus.o_queue_address, exp_addr);
            check_val("t5_order_data", bus.o_queue_data, exp_addr ^ KEY);
            exp_addr = exp_addr + 32'd4;
         end
         check_val("t5_le_depth", 32'(cnt <= 32'd4), 32'd1);
         exp_next = cnt + 32'(rdy) - 32'(vq);
         tick(1);
         check_val("t5_count", 32'(bus.o_queue_count), exp_next);
      end
      bus.i_queue_ready = 1'b0;

      // 6: asynchronous reset in the middle of a fetch
      do_reset();
      lat = 4;
      wait_log(2, 60);
      tick(1);
      #2 i_reset_n = 1'b0;
      #1 check_reset_outputs("t6");
      tick(2);
      fetch_log.delete();
      i_reset_n = 1'b1;
      wait_log(1, 20);
      check_val("t6_restart", fetch_log[0], 32'hFFFF_FFF0);
      wait_count(1, 20);
      check_val("t6_head_addr", bus.o_queue_address, 32'hFFFF_FFF0);
      check_val("t6_head_data", bus.o_queue_data, 32'hFFFF_FFF0 ^ KEY);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
